// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared fetch widths, reset PC and fetch-entry type
package fetch_buffer_pkg;

  localparam int PC_W = 15;
  localparam int INST_W = 16;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 15'h0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular queue of fetch entries with clear, push, pop and head
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  fetch_entry_t  entries [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !clear) entries[wr_ptr] <= wr_entry;
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction prefetch queue with memory bypass and flush redirect
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_raddr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  logic [PC_W-1:0] pc;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [AW:0]     count;
  logic [AW+1:0]   used;
  logic            issue;
  logic            push;
  logic            pop;
  logic            queue_empty;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;

  // Credits cover both queued entries and the read still in flight.
  assign used        = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign issue       = !flush && (used < DEPTH_V);
  assign queue_empty = (count == '0);
  assign imem_raddr  = pc;

  assign out_valid = !queue_empty || inflight;
  assign out_inst  = queue_empty ? imem_rdata : head.inst;
  assign out_pc    = queue_empty ? inflight_pc : head.pc;

  assign pop  = out_valid && out_ready && !flush;
  // Data consumed straight off the bypass is never enqueued.
  assign push = inflight && !flush && !(queue_empty && out_ready);

  assign wr_entry.pc   = inflight_pc;
  assign wr_entry.inst = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      pc       <= flush_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (push),
    .pop      (pop && !queue_empty),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction prefetch stage between instruction-memory read port 0 and decode.
- Streams sequential word addresses to memory, absorbs the 1-cycle synchronous read latency, and queues up to DEPTH fetched instructions with their PCs.
- Presents instructions to decode through a valid/ready handshake and redirects on an execute-stage flush.
- Lets decode and execute stalls (ld/ldp/stp sequencing) hold without re-fetching or losing instructions.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- PC_W, 15, word-address width (byte address bits [15:1]).
- INST_W, 16, instruction width.
- RESET_PC, 15'h0000, first word address fetched after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_raddr  out  PC_W  word address to the instruction-memory read port; data returns the following cycle.
- imem_rdata  in  INST_W  read data for the address issued in the previous cycle.
- flush  in  1  redirect request from execute (taken jump, already qualified by execute valid).
- flush_pc  in  PC_W  redirect target word address (jump target bits [15:1]).
- out_valid  out  1  out_inst and out_pc hold a valid instruction.
- out_inst  out  INST_W  instruction at the queue head, or bypassed memory data.
- out_pc  out  PC_W  word address of out_inst.
- out_ready  in  1  decode accepts the head this cycle; low means stall.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
  - On reset: pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, inflight=0, inflight_pc=0.
  - Outputs during reset: out_valid=0, imem_raddr=RESET_PC.
  - Reset asserted mid-operation discards the queue and any inflight read.
- State:
  - pc: next address to issue.
  - inflight: a read was issued last cycle.
  - inflight_pc: address of that read.
  - Circular queue of {pc, inst}: rd_ptr and wr_ptr of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- Issue:
  - imem_raddr = pc at all times.
  - issue = ~flush & (count + inflight < DEPTH).
  - On issue: pc <= pc+1, wrapping mod 2^PC_W (7FFF -> 0000); inflight <= 1; inflight_pc <= pc.
  - Otherwise inflight <= 0 and pc holds.
- Output mux, combinational:
  - out_valid = (count != 0) | inflight.
  - If count != 0: out_inst/out_pc = queue head.
  - Otherwise (bypass): out_inst = imem_rdata, out_pc = inflight_pc.
  - out_valid is not masked by flush; decode qualifies with flush itself.
- Handshake:
  - pop = out_valid & out_ready & ~flush.
  - push = inflight & ~flush & ~(count == 0 & out_ready). Returned data is not enqueued when it was consumed through the bypass.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Invariant: count + inflight <= DEPTH, so push never overflows. A bench assertion flags any push while count == DEPTH.
  - Full (count == DEPTH): no issue; pc holds until a pop.
  - Empty with no inflight read: out_valid=0; out_inst/out_pc are don't-care.
- Flush has priority over every other event in the same cycle:
  - pc <= flush_pc; count, rd_ptr and wr_ptr <= 0; inflight <= 0. The returning read belongs to the old path and is discarded.
  - Next cycle issues flush_pc. Its instruction appears at out_valid (bypass) 2 cycles after the flush cycle.
  - A flush asserted in consecutive cycles takes the last target.
- Latency:
  - Sequential fetch to decode: 1 cycle after issue.
  - Steady-state throughput: 1 instruction per cycle with out_ready held high.
- Stall release: after out_ready has been low for k cycles, the queue holds min(k, DEPTH) entries. Draining them is back-to-back, in order, with no gaps and no duplicates.

Decomposition:
- Shared package holds PC_W, INST_W, RESET_PC and the {pc, inst} fetch-entry typedef, also used by decode.
- One natural sub-module: fetch_fifo.
  - Synchronous-write circular buffer of DEPTH fetch entries.
  - Provides push/pop, count, and head output.
  - Same async active-high reset on clk/rst.
- fetch_buffer owns pc, inflight, the issue and credit logic, the bypass mux, and flush handling.

Test Plan:
- Reset then stream: memory word n = 16'h1000+n, out_ready=1 → out_valid from cycle 1 after reset release; out_pc 0,1,2,3… with out_inst 1000,1001,1002,1003 on consecutive cycles; count stays 0.
- Stall fill: out_ready=0 for 6 cycles from pc 0 → count saturates at 4, imem_raddr holds 0004. Release → 0000..0003 then 0004 delivered on 5 consecutive cycles, no duplicates.
- Flush with full queue: flush=1, flush_pc=15'h0100 → out_valid=0 next cycle; 2 cycles after the flush out_pc=0100, out_inst=mem[0100]; no stale 0004 ever delivered.
- Flush during inflight read with out_ready=0: issue addr 0007, flush to 0020 the next cycle → mem[0007] never enqueued; first delivered out_pc=0020.
- Wrap-around: flush_pc=7FFE, out_ready=1 → out_pc sequence 7FFE, 7FFF, 0000, 0001.
- Async reset mid-stream: rst pulsed between clock edges with count=3 → out_valid drops immediately and imem_raddr=0000; first delivered pc after release is 0000.
